// File: rtl/weight_ctrl_pkg.sv
// Shared types and the range check used by the weight-storage access arbiter.
package weight_ctrl_pkg;

  typedef logic [31:0] idx_t;

  typedef enum logic [1:0] {
    SRC_WR = 2'd0,
    SRC_UP = 2'd1,
    SRC_RD = 2'd2
  } src_t;

  localparam int unsigned LAYER_SIZE_DEF = 5;
  localparam int unsigned SIZE_DEF       = 3;

  function automatic logic in_range(idx_t layer, idx_t row,
                                    idx_t n_layers = idx_t'(LAYER_SIZE_DEF),
                                    idx_t n_rows   = idx_t'(SIZE_DEF));
    return (layer < n_layers) && (row < n_rows);
  endfunction

endpackage

// File: rtl/weight_access_arbiter_if.sv
// Requester handshakes plus the weight_storage command/read pins, bundled as one interface.
interface weight_access_arbiter_if #(
  parameter int data_size = 16,
  parameter int size      = 3
);
  import weight_ctrl_pkg::*;

  localparam int ROW_W = data_size * size;

  logic             wr_req;
  idx_t             wr_layer;
  idx_t             wr_row;
  logic [ROW_W-1:0] wr_data;
  logic             wr_ready;

  logic             up_req;
  idx_t             up_layer;
  idx_t             up_row;
  logic [ROW_W-1:0] up_dc_dw;
  logic             up_ready;

  logic             rd_req;
  idx_t             rd_layer;
  idx_t             rd_row;
  logic             rd_ready;
  logic [ROW_W-1:0] rd_data;
  logic             rd_valid;

  logic             err;
  logic [1:0]       err_src;

  logic             st_is_write;
  logic             st_is_update;
  logic             st_is_read;
  idx_t             st_write_layer_index;
  idx_t             st_write_row_index;
  logic [ROW_W-1:0] st_write_data;
  idx_t             st_layer_index;
  idx_t             st_row_index;
  logic [ROW_W-1:0] st_dc_dw;
  idx_t             st_w_layer_index;
  idx_t             st_w_row_index;
  logic [ROW_W-1:0] st_w;

  modport slave (
    input  wr_req, wr_layer, wr_row, wr_data,
    input  up_req, up_layer, up_row, up_dc_dw,
    input  rd_req, rd_layer, rd_row,
    input  st_w,
    output wr_ready, up_ready, rd_ready, rd_data, rd_valid, err, err_src,
    output st_is_write, st_is_update, st_is_read,
    output st_write_layer_index, st_write_row_index, st_write_data,
    output st_layer_index, st_row_index, st_dc_dw,
    output st_w_layer_index, st_w_row_index
  );

  modport master (
    output wr_req, wr_layer, wr_row, wr_data,
    output up_req, up_layer, up_row, up_dc_dw,
    output rd_req, rd_layer, rd_row,
    output st_w,
    input  wr_ready, up_ready, rd_ready, rd_data, rd_valid, err, err_src,
    input  st_is_write, st_is_update, st_is_read,
    input  st_write_layer_index, st_write_row_index, st_write_data,
    input  st_layer_index, st_row_index, st_dc_dw,
    input  st_w_layer_index, st_w_row_index
  );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; req/grant bit 0 = write, 1 = update, 2 = read.
module rr_arbiter3
  import weight_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant
);

  src_t ptr, ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) ptr <= SRC_WR;
    else     ptr <= ptr_nxt;
  end

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    // Grants are suppressed during reset so no transfer completes while rst is high.
    if (!rst) begin
      case (ptr)
        SRC_UP:  grant = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
        SRC_RD:  grant = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
        default: grant = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      endcase
    end
    if      (grant[0]) ptr_nxt = SRC_UP;
    else if (grant[1]) ptr_nxt = SRC_RD;
    else if (grant[2]) ptr_nxt = SRC_WR;
  end

endmodule

// File: rtl/weight_access_arbiter.sv
// Shares one weight_storage command port between loader, trainer and inference requesters.
module weight_access_arbiter
  import weight_ctrl_pkg::*;
#(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int layer_size = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  weight_access_arbiter_if.slave  bus
);

  localparam int ROW_W = data_size * size;

  logic [2:0] req, grant;
  logic       wr_ok, up_ok, rd_ok;
  logic       bad;
  src_t       bad_src;

  assign req = {bus.rd_req, bus.up_req, bus.wr_req};

  rr_arbiter3 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  assign bus.wr_ready = grant[0];
  assign bus.up_ready = grant[1];
  assign bus.rd_ready = grant[2];

  assign wr_ok = in_range(bus.wr_layer, bus.wr_row, idx_t'(layer_size), idx_t'(size));
  assign up_ok = in_range(bus.up_layer, bus.up_row, idx_t'(layer_size), idx_t'(size));
  assign rd_ok = in_range(bus.rd_layer, bus.rd_row, idx_t'(layer_size), idx_t'(size));

  always_comb begin
    bad     = 1'b0;
    bad_src = SRC_WR;
    if (grant[0] && !wr_ok) begin
      bad = 1'b1;
    end else if (grant[1] && !up_ok) begin
      bad     = 1'b1;
      bad_src = SRC_UP;
    end else if (grant[2] && !rd_ok) begin
      bad     = 1'b1;
      bad_src = SRC_RD;
    end
  end

  // Stage p0: command register onto the storage pins, error flag, first read tag
  logic             is_wr_p0, is_up_p0, is_rd_p0, err_p0;
  src_t             err_src_p0;
  logic             vld_p0, rd_ok_p0;
  idx_t             wr_layer_p0, wr_row_p0, up_layer_p0, up_row_p0, rd_layer_p0, rd_row_p0;
  logic [ROW_W-1:0] wr_data_p0, dc_dw_p0;
  logic             vld_p1, rd_ok_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_p0   <= 1'b0;
      is_up_p0   <= 1'b0;
      is_rd_p0   <= 1'b0;
      err_p0     <= 1'b0;
      err_src_p0 <= SRC_WR;
      vld_p0     <= 1'b0;
      rd_ok_p0   <= 1'b0;
      vld_p1     <= 1'b0;
      rd_ok_p1   <= 1'b0;
    end else begin
      is_wr_p0   <= grant[0] && wr_ok;
      is_up_p0   <= grant[1] && up_ok;
      is_rd_p0   <= grant[2] && rd_ok;
      err_p0     <= bad;
      err_src_p0 <= bad ? bad_src : SRC_WR;
      vld_p0     <= grant[2];
      rd_ok_p0   <= grant[2] && rd_ok;
      vld_p1     <= vld_p0;
      rd_ok_p1   <= rd_ok_p0;
    end
  end

  // Payload registers are unreset; the outputs are gated by their strobes instead.
  always_ff @(posedge clk) begin
    wr_layer_p0 <= bus.wr_layer;
    wr_row_p0   <= bus.wr_row;
    wr_data_p0  <= bus.wr_data;
    up_layer_p0 <= bus.up_layer;
    up_row_p0   <= bus.up_row;
    dc_dw_p0    <= bus.up_dc_dw;
    rd_layer_p0 <= bus.rd_layer;
    rd_row_p0   <= bus.rd_row;
  end

  assign bus.st_is_write          = is_wr_p0;
  assign bus.st_is_update         = is_up_p0;
  assign bus.st_is_read           = is_rd_p0;
  assign bus.st_write_layer_index = is_wr_p0 ? wr_layer_p0 : '0;
  assign bus.st_write_row_index   = is_wr_p0 ? wr_row_p0   : '0;
  assign bus.st_write_data        = is_wr_p0 ? wr_data_p0  : '0;
  assign bus.st_layer_index       = is_up_p0 ? up_layer_p0 : '0;
  assign bus.st_row_index         = is_up_p0 ? up_row_p0   : '0;
  assign bus.st_dc_dw             = is_up_p0 ? dc_dw_p0    : '0;
  assign bus.st_w_layer_index     = is_rd_p0 ? rd_layer_p0 : '0;
  assign bus.st_w_row_index       = is_rd_p0 ? rd_row_p0   : '0;
  assign bus.err                  = err_p0;
  assign bus.err_src              = err_src_p0;

  // Stage p1: storage output is registered by storage itself; dropped reads return zero
  assign bus.rd_valid = vld_p1;
  assign bus.rd_data  = rd_ok_p1 ? bus.st_w : '0;

endmodule
